ff_stim_gen: RTL and testbench
==============================

// Module: ff_stim_gen
// PURPOSE
//  Stimulus stage that feeds the enable-gated capture flip-flop in the CCRIO clock-pad testcase.
//  Drives its data_i and enable inputs from a 16-bit LFSR (data) and a programmable divider (enable).
//  Issues bursts of N enable pulses, or runs continuously. A bench or on-board checker can then
//  compare the flop's data_o against the known sequence.
// PARAMETERS
//  SEED     16'hACE1  LFSR load value; a value of 0 is replaced by 16'h0001
//  DIV_W    8         width of the enable-period divider
//  BURST_W  8         width of the burst length and pulse counter
// PORTS
//  clk          in   1        single clock, shared with the downstream flop
//  rst_n        in   1        asynchronous, active-low reset
//  start_i      in   1        level sampled each clk; starts a burst (honoured only in IDLE)
//  stop_i       in   1        abort; returns to IDLE next edge
//  hold_i       in   1        pause; divider frozen while high
//  div_i        in   DIV_W    enable period minus 1; latched at start
//  burst_len_i  in   BURST_W  number of enable pulses per burst; 0 = continuous; latched at start
//  data_o       out  1        to downstream data_i
//  enable_o     out  1        to downstream enable; one-cycle pulses
//  busy_o       out  1        high in RUN or HOLD
//  done_o       out  1        one-cycle pulse, coincident with the last enable_o of a burst
//  count_o      out  BURST_W  enable pulses issued in the current burst
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE, lfsr=SEED, every output 0.
//   - Reset asserted mid-burst aborts immediately; no done_o.
//  FSM states: IDLE, RUN, HOLD. Priority each edge: stop > hold > tick.
//   - IDLE, start_i=1, stop_i=0 -> RUN.
//     Latch div_i and burst_len_i. Load divider with div_i. Reload lfsr=SEED. count_o<=0.
//   - RUN: if divider==0, issue a tick and reload divider with div_l; else decrement divider.
//   - RUN, hold_i=1 -> HOLD. Divider, lfsr and count are frozen; enable_o=0.
//   - HOLD, hold_i=0 -> RUN.
//   - RUN or HOLD, stop_i=1 -> IDLE. No enable_o at that edge; done_o stays 0.
//   - start_i outside IDLE is ignored. In IDLE, start_i and stop_i together -> stays IDLE.
//  Tick (registered at one edge):
//   - enable_o<=1; data_o<=lfsr[0]; lfsr advances; count_o<=count_o+1.
//   - LFSR: fb = s[0]^s[2]^s[3]^s[5]; s <= {fb, s[15:1]}.
//   - enable_o is 0 on every non-tick cycle.
//  Timing:
//   - First enable_o is high in the cycle after edge (start edge + div+1).
//   - Subsequent enable_o pulses every div+1 cycles. div=0 -> enable_o high every RUN cycle.
//  Burst end (burst_len!=0):
//   - The tick that makes count == burst_len also sets done_o<=1 and state<=IDLE.
//   - done_o is high in the same cycle as that last enable_o.
//  Continuous mode (burst_len=0):
//   - count_o wraps 2^BURST_W-1 -> 0. done_o is never asserted.
//  In IDLE:
//   - data_o and count_o hold their last value; enable_o=0.
//   - lfsr is not reseeded until the next start.
// STRUCTURE
//  Package ff_stim_pkg:
//   - state enum {IDLE, RUN, HOLD}
//   - LFSR_W=16, LFSR tap mask 16'h002D
//   - SEED sanitising function
//  Sub-module ff_stim_lfsr: 16-bit Fibonacci LFSR with load/advance inputs; exposes out_bit and state.
//  Top level: FSM, divider, pulse counter, output registers.
// TESTING
//  1. Reset: rst_n=0 mid-burst -> all outputs 0 asynchronously. After release, state IDLE, no enable.
//  2. Sequence: div=0, len=4, start -> data_o=1,0,0,0 on 4 consecutive enables.
//     Internal lfsr ACE1->5670->AB38->559C. done_o with 4th enable; busy_o falls the next cycle.
//  3. Divider: div=3, len=3 -> enable_o on cycles 4, 8, 12 after the start edge.
//     No enable in between; count_o=1,2,3.
//  4. Hold and stop: div=1, len=0, hold for 5 cycles -> no enable, count frozen, resumes cadence.
//     stop_i together with a tick -> no enable, IDLE, done_o=0.
//  5. Wrap: BURST_W=3, div=0, len=0, 9 ticks -> count_o reaches 7, then 0, then 1; done_o never high.
//  6. Integration: feed the downstream flop -> its data_o tracks data_o on each enable edge.

Source files
------------

// File: rtl/ff_stim_pkg.sv
// Shared types and constants for the capture-flop stimulus generator.
// Holds the FSM state enum, LFSR geometry and the seed sanitiser.
package ff_stim_pkg;

    localparam int LFSR_W = 16;

    // Feedback taps s[0], s[2], s[3], s[5]
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } state_e;

    // An all-zero LFSR never leaves zero, so swap it for 1
    function automatic logic [LFSR_W-1:0] seed_fix(
        input logic [LFSR_W-1:0] s
    );
        return (s == '0) ? LFSR_W'(1) : s;
    endfunction

endpackage

// File: rtl/ff_stim_lfsr.sv
// 16-bit Fibonacci LFSR, shifting right with feedback into the MSB.
// Ports: clk, rst_n, load_i (reseed), adv_i (step), out_bit_o (s[0]), state_o.
module ff_stim_lfsr
    import ff_stim_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              adv_i,
    output logic              out_bit_o,
    output logic [LFSR_W-1:0] state_o
);

    logic [LFSR_W-1:0] s_q;
    logic [LFSR_W-1:0] s_d;
    logic              fb;

    assign fb = ^(s_q & LFSR_TAPS);

    always_comb begin
        s_d = s_q;
        if (load_i) begin
            s_d = seed_fix(SEED);
        end else if (adv_i) begin
            s_d = {fb, s_q[LFSR_W-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q <= seed_fix(SEED);
        end else begin
            s_q <= s_d;
        end
    end

    assign out_bit_o = s_q[0];
    assign state_o   = s_q;

endmodule

// File: rtl/ff_stim_gen.sv
// Stimulus generator for an enable-gated capture flop: LFSR data plus
// divided enable pulses, in bursts of burst_len_i or continuously.
// Ports: clk, rst_n, start_i, stop_i, hold_i, div_i, burst_len_i ->
//        data_o, enable_o, busy_o, done_o, count_o.
module ff_stim_gen
    import ff_stim_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED    = 16'hACE1,
    parameter int                DIV_W   = 8,
    parameter int                BURST_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               hold_i,
    input  logic [DIV_W-1:0]   div_i,
    input  logic [BURST_W-1:0] burst_len_i,
    output logic               data_o,
    output logic               enable_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [BURST_W-1:0] count_o
);

    state_e             state_q;
    logic [DIV_W-1:0]   div_l_q;
    logic [DIV_W-1:0]   divcnt_q;
    logic [BURST_W-1:0] len_l_q;
    logic [BURST_W-1:0] count_q;
    logic               data_q;
    logic               en_q;
    logic               done_q;

    logic               active;
    logic               tick;
    logic               load;
    logic               last;
    logic [BURST_W-1:0] count_inc;
    logic               lfsr_bit;
    logic [LFSR_W-1:0]  lfsr_unused;

    // Divider only moves on edges that are neither stopped nor held
    assign active    = (state_q != IDLE) && !stop_i && !hold_i;
    assign tick      = active && (divcnt_q == '0);
    assign load      = (state_q == IDLE) && start_i && !stop_i;
    assign count_inc = count_q + BURST_W'(1);
    // Length 0 means continuous, so the wrap to 0 must not end it
    assign last      = tick && (len_l_q != '0) && (count_inc == len_l_q);

    ff_stim_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (load),
        .adv_i     (tick),
        .out_bit_o (lfsr_bit),
        .state_o   (lfsr_unused)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            div_l_q  <= '0;
            divcnt_q <= '0;
            len_l_q  <= '0;
            count_q  <= '0;
            data_q   <= 1'b0;
            en_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            en_q   <= tick;
            done_q <= last;
            unique case (state_q)
                IDLE: begin
                    if (load) begin
                        state_q  <= RUN;
                        div_l_q  <= div_i;
                        divcnt_q <= div_i;
                        len_l_q  <= burst_len_i;
                        count_q  <= '0;
                    end
                end
                RUN, HOLD: begin
                    if (stop_i) begin
                        state_q <= IDLE;
                    end else if (hold_i) begin
                        state_q <= HOLD;
                    end else begin
                        state_q <= last ? IDLE : RUN;
                        if (tick) begin
                            divcnt_q <= div_l_q;
                            data_q   <= lfsr_bit;
                            count_q  <= count_inc;
                        end else begin
                            divcnt_q <= divcnt_q - DIV_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_o   = data_q;
    assign enable_o = en_q;
    assign done_o   = done_q;
    assign count_o  = count_q;
    // Stays high through the done cycle, drops on the one after
    assign busy_o   = (state_q != IDLE) || done_q;

endmodule

// File: tb/tb_ff_stim_gen.sv
// Self-checking bench for ff_stim_gen with a behavioural model,
// a downstream capture flop and directed literal expectations.
module tb_ff_stim_gen;

    localparam int DIV_W   = 8;
    localparam int BURST_W = 3;

    logic               clk     = 1'b0;
    logic               rst_n   = 1'b0;
    logic               start   = 1'b0;
    logic               stop    = 1'b0;
    logic               hold    = 1'b0;
    logic [DIV_W-1:0]   div     = '0;
    logic [BURST_W-1:0] len     = '0;
    logic               data;
    logic               en;
    logic               busy;
    logic               done;
    logic [BURST_W-1:0] cnt;
    logic               ds_q;

    int n_chk  = 0;
    int n_pass = 0;

    ff_stim_gen #(
        .SEED    (16'hACE1),
        .DIV_W   (DIV_W),
        .BURST_W (BURST_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start),
        .stop_i      (stop),
        .hold_i      (hold),
        .div_i       (div),
        .burst_len_i (len),
        .data_o      (data),
        .enable_o    (en),
        .busy_o      (busy),
        .done_o      (done),
        .count_o     (cnt)
    );

    always #5 clk = ~clk;

    // Downstream enable-gated capture flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ds_q <= 1'b0;
        else if (en) ds_q <= data;
    end

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    endtask

    function automatic int unsigned lfsr_next(int unsigned s);
        int unsigned fb;
        fb = (s ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 1;
        return ((s >> 1) | (fb << 15)) & 32'hFFFF;
    endfunction

    // Model: count enabled edges since start; every (div+1)-th is a tick
    bit          m_act  = 0;
    int          m_div  = 0;
    int          m_len  = 0;
    int          m_n    = 0;
    int          m_cnt  = 0;
    int unsigned m_lfsr = 32'hACE1;
    bit          m_en   = 0;
    bit          m_data = 0;
    bit          m_done = 0;
    bit          m_q    = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act  = 0;
            m_cnt  = 0;
            m_lfsr = 32'hACE1;
            m_en   = 0;
            m_data = 0;
            m_done = 0;
            m_q    = 0;
        end else begin
            if (m_en) m_q = m_data;
            m_en   = 0;
            m_done = 0;
            if (!m_act) begin
                if (start && !stop) begin
                    m_act  = 1;
                    m_div  = int'(div);
                    m_len  = int'(len);
                    m_n    = 0;
                    m_lfsr = 32'hACE1;
                    m_cnt  = 0;
                end
            end else if (stop) begin
                m_act = 0;
            end else if (!hold) begin
                m_n++;
                if (m_n % (m_div + 1) == 0) begin
                    m_en   = 1;
                    m_data = m_lfsr[0];
                    m_lfsr = lfsr_next(m_lfsr);
                    m_cnt  = (m_cnt + 1) % (1 << BURST_W);
                    if (m_len != 0 && m_cnt == m_len) begin
                        m_done = 1;
                        m_act  = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("enable", int'(en), int'(m_en));
        chk("data", int'(data), int'(m_data));
        chk("done", int'(done), int'(m_done));
        chk("busy", int'(busy), int'(m_act || m_done));
        chk("count", int'(cnt), m_cnt);
        chk("ds_flop", int'(ds_q), int'(m_q));
    end

    task automatic edge_();
        @(posedge clk);
        #1;
    endtask

    int seq2[4] = '{1, 0, 0, 0};

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_en", int'(en), 0);
        chk("rst_data", int'(data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_count", int'(cnt), 0);
        rst_n = 1'b1;
        edge_();

        // Sequence: div 0, length 4
        div = 8'd0; len = 3'd4; start = 1'b1;
        edge_();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            edge_();
            chk("seq_en", int'(en), 1);
            chk("seq_data", int'(data), seq2[k]);
            chk("seq_done", int'(done), (k == 3) ? 1 : 0);
            chk("seq_count", int'(cnt), k + 1);
            chk("seq_busy", int'(busy), 1);
            if (k == 1) chk("ds_lit", int'(ds_q), 1);
        end
        edge_();
        chk("seq_busy_fall", int'(busy), 0);
        chk("seq_idle_en", int'(en), 0);

        // Divider: div 3, length 3
        div = 8'd3; len = 3'd3; start = 1'b1;
        edge_();
        start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            edge_();
            chk("div_en", int'(en), (c % 4 == 0) ? 1 : 0);
            if (c % 4 == 0) chk("div_count", int'(cnt), c / 4);
            chk("div_done", int'(done), (c == 12) ? 1 : 0);
        end
        edge_();

        // Hold then stop: div 1, continuous
        div = 8'd1; len = 3'd0; start = 1'b1;
        edge_();
        start = 1'b0;
        repeat (4) edge_();
        chk("hold_pre_en", int'(en), 1);
        chk("hold_pre_cnt", int'(cnt), 2);
        hold = 1'b1;
        for (int c = 0; c < 5; c++) begin
            edge_();
            chk("hold_en", int'(en), 0);
            chk("hold_cnt", int'(cnt), 2);
            chk("hold_busy", int'(busy), 1);
        end
        hold = 1'b0;
        edge_();
        chk("resume_gap", int'(en), 0);
        edge_();
        chk("resume_en", int'(en), 1);
        chk("resume_cnt", int'(cnt), 3);
        edge_();
        stop = 1'b1;
        edge_();
        stop = 1'b0;
        chk("stop_en", int'(en), 0);
        chk("stop_done", int'(done), 0);
        chk("stop_busy", int'(busy), 0);
        chk("stop_cnt", int'(cnt), 3);

        // Start together with stop stays idle
        start = 1'b1; stop = 1'b1;
        edge_();
        start = 1'b0; stop = 1'b0;
        chk("startstop_busy", int'(busy), 0);
        edge_();

        // Continuous wrap of the 3-bit counter
        div = 8'd0; len = 3'd0; start = 1'b1;
        edge_();
        start = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            edge_();
            chk("wrap_cnt", int'(cnt), k % 8);
            chk("wrap_en", int'(en), 1);
            chk("wrap_done", int'(done), 0);
        end
        stop = 1'b1;
        edge_();
        stop = 1'b0;

        // Asynchronous reset mid-burst
        div = 8'd0; len = 3'd5; start = 1'b1;
        edge_();
        start = 1'b0;
        edge_();
        chk("pre_rst_en", int'(en), 1);
        chk("pre_rst_data", int'(data), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_en", int'(en), 0);
        chk("arst_data", int'(data), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_count", int'(cnt), 0);
        edge_();
        rst_n = 1'b1;
        repeat (3) edge_();
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_en", int'(en), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
